ama_riscv_pipe_ctrl: RTL

Central pipeline sequencer for the 5-stage core (fet, dec, exe, mem, wbk). It decides every cycle which stage registers hold, which receive a NOP bubble (`addi x0,x0,0`) and which are flushed to all-zeros. It covers load-use hazards, branch/jump redirects, data-memory stalls and serializing instructions (fence.i, CSR). It also keeps saturating event counters for performance visibility.

---
 rtl/ama_riscv_pipe_ctrl_pkg.sv | 24 ++
 rtl/ama_riscv_pipe_ctrl_hazard_det.sv | 21 ++
 rtl/ama_riscv_pipe_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ama_riscv_pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer states, NOP encoding, event indices.
package ama_riscv_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DMISS  = 2'd1,
        REFILL = 2'd2,
        DRAIN  = 2'd3
    } pipe_ctrl_state_t;

    // addi x0,x0,0 -- the bubble loaded into a stage register
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Event counter slots
    localparam int EVT_LDU   = 0;
    localparam int EVT_REDIR = 1;
    localparam int EVT_DMISS = 2;
    localparam int EVT_DRAIN = 3;
    localparam int N_EVT     = 4;

    // Refill countdown width; covers REDIRECT_BUBBLES up to 3
    localparam int REFILL_W = 2;

endpackage

// File: rtl/ama_riscv_pipe_ctrl_hazard_det.sv
// Load-use detector: exe load whose rd (non-x0) matches a source the dec instruction reads.
module ama_riscv_hazard_det (
    input  logic [4:0] dec_rs1_addr,
    input  logic [4:0] dec_rs2_addr,
    input  logic       dec_rs1_used,
    input  logic       dec_rs2_used,
    input  logic [4:0] exe_rd_addr,
    input  logic       exe_is_load,
    output logic       load_use
);

    // x0 is never a real dependency; unused sources never create one
    always_comb begin
        load_use = 1'b0;
        if (exe_is_load && (exe_rd_addr != 5'd0)) begin
            load_use = (dec_rs1_used && (dec_rs1_addr == exe_rd_addr)) ||
                       (dec_rs2_used && (dec_rs2_addr == exe_rd_addr));
        end
    end

endmodule

// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline sequencer: per-cycle stall/bubble/flush decisions plus saturating event counters.
module ama_riscv_pipe_ctrl
    import ama_riscv_pipe_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       dec_rs1_addr,
    input  logic [4:0]       dec_rs2_addr,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic             dec_serialize,
    input  logic [4:0]       exe_rd_addr,
    input  logic             exe_is_load,
    input  logic             exe_redirect,
    input  logic             exe_valid,
    input  logic             mem_valid,
    input  logic             wbk_valid,
    input  logic             dmem_busy,
    output logic             stall_fet,
    output logic             stall_dec,
    output logic             stall_exe,
    output logic             stall_mem,
    output logic             bubble_dec,
    output logic             bubble_exe,
    output logic             flush_dec,
    output logic             flush_exe,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] cnt_ldu,
    output logic [CNT_W-1:0] cnt_redir,
    output logic [CNT_W-1:0] cnt_dmiss,
    output logic [CNT_W-1:0] cnt_drain
);

    pipe_ctrl_state_t    state_q, state_d;
    pipe_ctrl_state_t    resume_q, resume_d;
    pipe_ctrl_state_t    eff_state;
    logic [REFILL_W-1:0] refill_q, refill_d;
    logic [N_EVT-1:0]    evt;
    logic                load_use;
    logic                ser_stall;
    logic [CNT_W-1:0]    cnt_all [N_EVT];

    ama_riscv_hazard_det u_hazard_det (
        .dec_rs1_addr (dec_rs1_addr),
        .dec_rs2_addr (dec_rs2_addr),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .exe_rd_addr  (exe_rd_addr),
        .exe_is_load  (exe_is_load),
        .load_use     (load_use)
    );

    // Once the miss clears, behave as the state that was interrupted
    assign eff_state  = (state_q == DMISS) ? resume_q : state_q;
    assign ser_stall  = dec_serialize && (exe_valid || mem_valid || wbk_valid);
    assign ctrl_state = state_q;

    // Priority decode: dmem stall, redirect, refill, serialize drain, load-use
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        refill_d   = refill_q;
        evt        = '0;
        stall_fet  = 1'b0;
        stall_dec  = 1'b0;
        stall_exe  = 1'b0;
        stall_mem  = 1'b0;
        bubble_dec = 1'b0;
        bubble_exe = 1'b0;
        flush_dec  = 1'b0;
        flush_exe  = 1'b0;
        if (dmem_busy) begin
            stall_fet = 1'b1;
            stall_dec = 1'b1;
            stall_exe = 1'b1;
            stall_mem = 1'b1;
            state_d   = DMISS;
            if (state_q != DMISS) begin
                resume_d       = state_q;
                evt[EVT_DMISS] = 1'b1;
            end
        end else if (exe_redirect) begin
            flush_dec      = 1'b1;
            flush_exe      = 1'b1;
            refill_d       = REFILL_W'(REDIRECT_BUBBLES);
            state_d        = REFILL;
            evt[EVT_REDIR] = 1'b1;
        end else if (eff_state == REFILL) begin
            bubble_dec = 1'b1;
            stall_fet  = 1'b1;
            refill_d   = (refill_q == '0) ? '0 : refill_q - 1'b1;
            state_d    = (refill_q <= REFILL_W'(1)) ? RUN : REFILL;
        end else if (ser_stall) begin
            stall_fet  = 1'b1;
            stall_dec  = 1'b1;
            bubble_exe = 1'b1;
            state_d    = DRAIN;
            if (eff_state != DRAIN) begin
                evt[EVT_DRAIN] = 1'b1;
            end
        end else begin
            // Drain complete (or nothing pending): the dec instruction issues now
            state_d = RUN;
            if (load_use) begin
                stall_fet    = 1'b1;
                stall_dec    = 1'b1;
                bubble_exe   = 1'b1;
                evt[EVT_LDU] = 1'b1;
            end
        end
    end

    // Sequencer state, miss-resume record and refill countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            resume_q <= RUN;
            refill_q <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            refill_q <= refill_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_EVT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_d, cnt_q;

            // Count one per event entry, sticking at all-ones
            always_comb begin
                cnt_d = cnt_q;
                if (evt[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign cnt_ldu   = cnt_all[EVT_LDU];
    assign cnt_redir = cnt_all[EVT_REDIR];
    assign cnt_dmiss = cnt_all[EVT_DMISS];
    assign cnt_drain = cnt_all[EVT_DRAIN];

endmodule
